// File: rtl/serial_deser_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
package serial_deser_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a 1-bit stream
// and presents them on a valid/ready output register with abort/overrun flags.
module serial_deser
   import serial_deser_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;

   logic [CW-1:0]    idx_c;
   logic [WIDTH-1:0] word_c;
   logic             last_c;

   // Current bit merged into the partial word so the last bit loads dout directly.
   always_comb begin
      idx_c  = MSB_FIRST ? (CW'(WIDTH - 1) - cnt) : cnt;
      word_c = shreg;
      word_c[idx_c] = sin;
      last_c = (state == ST_SHIFT) && sin_en && (cnt == CW'(WIDTH - 1));
   end

   assign busy = (state == ST_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (sin_en) begin
                  shreg <= word_c;
                  cnt   <= CW'(1);
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (!sin_en) begin
                  frame_err <= 1'b1;
                  cnt       <= '0;
                  shreg     <= '0;
                  state     <= ST_IDLE;
               end else if (last_c) begin
                  cnt   <= '0;
                  shreg <= '0;
                  state <= ST_IDLE;
               end else begin
                  shreg <= word_c;
                  cnt   <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Output slice: a full, unaccepted register drops the new word.
         if (last_c) begin
            if (!dout_valid || dout_ready) begin
               dout       <= word_c;
               dout_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: LSB-first and MSB-first instances share one stimulus
// stream and are compared every cycle against a queue-based frame model.
module tb_serial_deser;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         sin;
   logic         sin_en;
   logic         dout_ready;

   logic [W-1:0] dout_l, dout_m;
   logic         valid_l, valid_m, busy_l, busy_m;
   logic         ferr_l, ferr_m, ovr_l, ovr_m;

   int checks = 0;
   int errors = 0;

   // Reference state: bits of the partial frame, plus the output register.
   bit           q[$];
   logic [W-1:0] m_dout_l, m_dout_m;
   logic         m_valid, m_ferr, m_ovr;

   serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
      .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
      .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l)
   );

   serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
      .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
      .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model one clock edge from the inputs present before it.
   task automatic model_edge();
      logic [W-1:0] wl, wm;
      bit           done;
      if (rst) begin
         q.delete();
         m_dout_l = '0; m_dout_m = '0;
         m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         return;
      end
      m_ferr = 1'b0;
      done   = 1'b0;
      wl = '0; wm = '0;
      if (sin_en) begin
         q.push_back(sin);
         if (q.size() == W) begin
            for (int i = 0; i < W; i++) begin
               wl[i]       = q[i];
               wm[W-1-i]   = q[i];
            end
            done = 1'b1;
            q.delete();
         end
      end else if (q.size() > 0) begin
         m_ferr = 1'b1;
         q.delete();
      end
      if (done) begin
         if (!m_valid || dout_ready) begin
            m_dout_l = wl; m_dout_m = wm; m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && dout_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("dout_lsb",  32'(dout_l),  32'(m_dout_l));
      chk("dout_msb",  32'(dout_m),  32'(m_dout_m));
      chk("valid_lsb", 32'(valid_l), 32'(m_valid));
      chk("valid_msb", 32'(valid_m), 32'(m_valid));
      chk("busy_lsb",  32'(busy_l),  32'(q.size() > 0));
      chk("busy_msb",  32'(busy_m),  32'(q.size() > 0));
      chk("ferr_lsb",  32'(ferr_l),  32'(m_ferr));
      chk("ferr_msb",  32'(ferr_m),  32'(m_ferr));
      chk("ovr_lsb",   32'(ovr_l),   32'(m_ovr));
      chk("ovr_msb",   32'(ovr_m),   32'(m_ovr));
   endtask

   task automatic cycle(input logic r, input logic b, input logic en, input logic rdy);
      rst = r; sin = b; sin_en = en; dout_ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic send_word(input logic [W-1:0] bits_lsb_first, input logic rdy);
      for (int i = 0; i < W; i++) cycle(1'b0, bits_lsb_first[i], 1'b1, rdy);
   endtask

   initial begin
      q.delete();
      m_dout_l = '0; m_dout_m = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      rst = 1'b1; sin = 1'b1; sin_en = 1'b1; dout_ready = 1'b1;

      // Reset held two cycles while sin_en is high.
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("reset_valid", 32'(valid_l), 32'd0);
      chk("reset_busy",  32'(busy_l),  32'd0);

      // Single word, bits 1,0,1,1 in arrival order.
      send_word(4'b1101, 1'b1);
      chk("single_dout", 32'(dout_l), 32'h0000_000d);
      chk("single_vld",  32'(valid_l), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("single_drop", 32'(valid_l), 32'd0);

      // Back-to-back words 1111 then 0011 without a gap.
      send_word(4'b1111, 1'b1);
      chk("b2b_first", 32'(dout_l), 32'h0000_000f);
      send_word(4'b0011, 1'b1);
      chk("b2b_second", 32'(dout_l), 32'h0000_0003);
      chk("b2b_valid",  32'(valid_l), 32'd1);
      chk("b2b_ovr",    32'(ovr_l),   32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Abort after two bits, then 0,1,0,1.
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_ferr",  32'(ferr_l),  32'd1);
      chk("abort_valid", 32'(valid_l), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("abort_pulse", 32'(ferr_l), 32'd0);
      for (int i = 1; i < W; i++) cycle(1'b0, i[0], 1'b1, 1'b1);
      chk("abort_next", 32'(dout_l), 32'h0000_000a);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: not ready, 0001 then 1110.
      send_word(4'b0001, 1'b0);
      send_word(4'b1110, 1'b0);
      chk("ovr_dout", 32'(dout_l), 32'h0000_0001);
      chk("ovr_flag", 32'(ovr_l),  32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_sticky", 32'(ovr_l), 32'd1);

      // Mid-frame reset after three bits, then 1,0,0,0.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("midrst_busy", 32'(busy_m), 32'd0);
      chk("midrst_ferr", 32'(ferr_m), 32'd0);
      chk("midrst_ovr",  32'(ovr_m),  32'd0);
      send_word(4'b0001, 1'b1);
      chk("msb_dout", 32'(dout_m), 32'h0000_0008);

      // Random traffic, occasional reset.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
